// File: rtl/wma_pkg.sv
// Shared limits and width helpers for the weighted moving average filter.
package wma_pkg;

  localparam int WMA_MAX_TAPS   = 16;
  localparam int WMA_MAX_DATA_W = 16;
  // Pair sums and the final sum each need one guard bit over the sample width.
  localparam int WMA_SUM_GROW   = 1;
  localparam int WMA_SUM_W_MAX  = WMA_MAX_DATA_W + WMA_SUM_GROW;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int wma_sum_w(input int data_w);
    return data_w + WMA_SUM_GROW;
  endfunction

endpackage

// File: rtl/wma_filter_pipe_if.sv
// Sample-in / result-out valid-ready bundle for wma_filter_pipe.
interface wma_filter_pipe_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] Xn;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] Yn;
  logic              out_valid;
  logic              out_ready;
  logic              out_full;
  logic              out_ovf;

  modport slave (
    input  Xn, in_valid, out_ready,
    output in_ready, Yn, out_valid, out_full, out_ovf
  );

  modport master (
    output Xn, in_valid, out_ready,
    input  in_ready, Yn, out_valid, out_full, out_ovf
  );
endinterface

// File: rtl/wma_tap_line.sv
// Sample delay line with saturating fill counter; CLR wins over a same-cycle accept.
module wma_tap_line
  import wma_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int TAPS   = 4,
  localparam int CNT_W = clog2(TAPS + 1)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         CLR,
  input  logic                         accept,
  input  logic [DATA_W-1:0]            xn,
  output logic [TAPS-1:0][DATA_W-1:0]  tap_q,
  output logic                         full_next
);

  logic [TAPS-1:0][DATA_W-1:0] tap_d;
  logic [CNT_W-1:0]            fill_d, fill_q, fill_acc;

  always_comb begin
    fill_acc = fill_q;
    if (accept && (fill_q != CNT_W'(TAPS))) fill_acc = fill_q + 1'b1;
  end

  // Window is full once the count, including this cycle's sample, reaches TAPS.
  assign full_next = (fill_acc == CNT_W'(TAPS));

  always_comb begin
    tap_d  = tap_q;
    fill_d = fill_acc;
    if (CLR) begin
      tap_d  = '0;
      fill_d = '0;
    end else if (accept) begin
      tap_d = {tap_q[TAPS-2:0], xn};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tap_q  <= '0;
      fill_q <= '0;
    end else begin
      tap_q  <= tap_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/wma_filter_pipe.sv
// Pipelined weighted moving average Yn = sum(x[n-k] >> k); tap line, pair adders, final sum.
// Optional saturating output when WMA_SAT_EN is defined; otherwise Yn wraps.
module wma_filter_pipe
  import wma_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int TAPS   = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           CLR,
  wma_filter_pipe_if.slave s
);

  localparam int PAIRS  = TAPS / 2;
  localparam int SUM_W  = wma_sum_w(DATA_W);
  localparam int STAGES = 2;

  logic                          adv, accept, full_next;
  logic [TAPS-1:0][DATA_W-1:0]   tap, term;
  logic [PAIRS-1:0][SUM_W-1:0]   pair_new, pair_d, pair_q;
  logic [SUM_W-1:0]              sum_new, sum_d, sum_q;
  // [0] taps hold a fresh sample, [1] pair stage, [STAGES] output register
  logic [STAGES:0]               vld_pipe_d, vld_pipe_q;
  logic [STAGES:0]               full_pipe_d, full_pipe_q;

  assign adv        = !vld_pipe_q[STAGES] || s.out_ready;
  assign accept     = s.in_valid && adv;
  assign s.in_ready = adv;

  wma_tap_line #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS)
  ) u_tap_line (
    .CLK       (CLK),
    .RST       (RST),
    .CLR       (CLR),
    .accept    (accept),
    .xn        (s.Xn),
    .tap_q     (tap),
    .full_next (full_next)
  );

  // Per-term truncation; taps past the sample width contribute nothing.
  always_comb begin
    for (int k = 0; k < TAPS; k++)
      term[k] = (k < DATA_W) ? (tap[k] >> k) : '0;
  end

  always_comb begin
    for (int j = 0; j < PAIRS; j++)
      pair_new[j] = SUM_W'(term[2*j]) + SUM_W'(term[2*j+1]);
  end

  // Exact sum is bounded below 2^(DATA_W+1), so SUM_W never truncates.
  always_comb begin
    sum_new = '0;
    for (int j = 0; j < PAIRS; j++)
      sum_new = sum_new + pair_q[j];
  end

  always_comb begin
    vld_pipe_d  = vld_pipe_q;
    full_pipe_d = full_pipe_q;
    pair_d      = pair_q;
    sum_d       = sum_q;
    if (CLR) begin
      vld_pipe_d  = '0;
      full_pipe_d = '0;
      pair_d      = '0;
      sum_d       = '0;
    end else if (adv) begin
      vld_pipe_d  = {vld_pipe_q[STAGES-1:0], accept};
      full_pipe_d = {full_pipe_q[STAGES-1:0], full_next};
      pair_d      = pair_new;
      sum_d       = sum_new;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_pipe_q  <= '0;
      full_pipe_q <= '0;
      pair_q      <= '0;
      sum_q       <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      full_pipe_q <= full_pipe_d;
      pair_q      <= pair_d;
      sum_q       <= sum_d;
    end
  end

  assign s.out_valid = vld_pipe_q[STAGES];
  assign s.out_full  = full_pipe_q[STAGES];
  assign s.out_ovf   = sum_q[DATA_W];

`ifdef WMA_SAT_EN
  assign s.Yn = sum_q[DATA_W] ? '1 : sum_q[DATA_W-1:0];
`else
  assign s.Yn = sum_q[DATA_W-1:0];
`endif

endmodule

// File: tb/tb_wma_filter_pipe.sv
// Bench for wma_filter_pipe: directed test-plan sequences plus random traffic vs a window model.
module tb_wma_filter_pipe;

  localparam int DW = 8;
  localparam int TP = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic CLR = 1'b0;

  wma_filter_pipe_if #(.DATA_W(DW)) bus ();

  wma_filter_pipe #(.DATA_W(DW), .TAPS(TP)) dut (
    .CLK (CLK),
    .RST (RST),
    .CLR (CLR),
    .s   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit v;
    int y;
    bit f;
    bit o;
  } slot_t;

  int    checks = 0;
  int    errors = 0;
  slot_t pipe[3];        // [0] newest window, [2] what the output should show
  int    hist[TP];       // hist[0] is the newest accepted sample
  int    fill;
  int    got_y[$];
  bit    got_f[$];
  bit    got_o[$];
  int    nacc, ntx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Weighted sum of the current window, expressed from the filter equation.
  function automatic slot_t eval_window(input bit v);
    slot_t r;
    int sum;
    sum = 0;
    for (int k = 0; k < TP; k++)
      if (k < DW) sum += hist[k] / (1 << k);
    r.v = v;
    r.o = (sum >= (1 << DW));
`ifdef WMA_SAT_EN
    r.y = r.o ? (1 << DW) - 1 : sum;
`else
    r.y = sum % (1 << DW);
`endif
    r.f = (fill == TP);
    return r;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < TP; k++) hist[k] = 0;
    fill = 0;
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
  endfunction

  function automatic int qy(input int i);
    return (got_y.size() > i) ? got_y[i] : -1;
  endfunction

  function automatic int qf(input int i);
    return (got_f.size() > i) ? int'(got_f[i]) : -1;
  endfunction

  function automatic void clear_got();
    got_y.delete();
    got_f.delete();
    got_o.delete();
  endfunction

  // One clock: drive at negedge, check the settled outputs, then advance the model.
  task automatic cyc(input bit iv, input int x, input bit ordy, input bit clr);
    bit adv, acc;
    @(negedge CLK);
    bus.in_valid  = iv;
    bus.Xn        = 8'(x);
    bus.out_ready = ordy;
    CLR           = clr;
    #1;
    adv = !pipe[2].v || ordy;
    chk("in_ready",  bus.in_ready,  32'(adv));
    chk("out_valid", bus.out_valid, 32'(pipe[2].v));
    chk("Yn",        bus.Yn,        32'(pipe[2].y));
    chk("out_full",  bus.out_full,  32'(pipe[2].f));
    chk("out_ovf",   bus.out_ovf,   32'(pipe[2].o));
    if (pipe[2].v && ordy) begin
      got_y.push_back(int'(bus.Yn));
      got_f.push_back(bus.out_full);
      got_o.push_back(bus.out_ovf);
      ntx++;
    end
    acc = iv && adv;
    if (clr) begin
      model_clear();
    end else if (adv) begin
      if (acc) begin
        for (int k = TP - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x % (1 << DW);
        if (fill < TP) fill++;
        nacc++;
      end
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = eval_window(acc);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, bus.out_valid, 32'd0);
    chk({tag, "_Yn"},    bus.Yn,        32'd0);
    chk({tag, "_full"},  bus.out_full,  32'd0);
    chk({tag, "_ovf"},   bus.out_ovf,   32'd0);
    chk({tag, "_inrdy"}, bus.in_ready,  32'd1);
  endtask

  initial begin
    int exp_sat;
    bus.in_valid  = 1'b0;
    bus.Xn        = '0;
    bus.out_ready = 1'b0;
    nacc = 0;
    ntx  = 0;
    model_clear();

    #3;
    check_reset_outputs("rst0");
    #4 RST = 1'b1;

    // Impulse response from a fresh window.
    clear_got();
    cyc(1'b1, 128, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 0, 1'b1, 1'b0);
    drain(4);
    chk("imp_y0", 32'(qy(0)), 32'd128);
    chk("imp_y1", 32'(qy(1)), 32'd64);
    chk("imp_y2", 32'(qy(2)), 32'd32);
    chk("imp_y3", 32'(qy(3)), 32'd16);
    chk("imp_y4", 32'(qy(4)), 32'd0);
    chk("imp_f2", 32'(qf(2)), 32'd0);
    chk("imp_f3", 32'(qf(3)), 32'd1);

    // Constant full-scale input: overflow, wrap or saturate.
    cyc(1'b0, 0, 1'b1, 1'b1);
    clear_got();
    for (int i = 0; i < 8; i++) cyc(1'b1, 255, 1'b1, 1'b0);
    drain(3);
`ifdef WMA_SAT_EN
    exp_sat = 255;
`else
    exp_sat = 220;
`endif
    chk("c255_y",   32'(got_y.size() > 0 ? got_y[$] : -1), 32'(exp_sat));
    chk("c255_ovf", 32'(got_o.size() > 0 ? int'(got_o[$]) : -1), 32'd1);

    // Constant 100: no overflow.
    cyc(1'b0, 0, 1'b1, 1'b1);
    clear_got();
    for (int i = 0; i < 8; i++) cyc(1'b1, 100, 1'b1, 1'b0);
    drain(3);
    chk("c100_y",   32'(got_y.size() > 0 ? got_y[$] : -1), 32'd187);
    chk("c100_ovf", 32'(got_o.size() > 0 ? int'(got_o[$]) : -1), 32'd0);

    // Backpressure with in_valid held high.
    cyc(1'b0, 0, 1'b1, 1'b1);
    nacc = 0;
    ntx  = 0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 10 * i + 5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 7, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 40 + i, 1'b1, 1'b0);
    drain(4);
    chk("bp_count", 32'(ntx), 32'(nacc));

    // CLR with a simultaneous valid sample drops it and restarts the window.
    cyc(1'b0, 0, 1'b1, 1'b1);
    cyc(1'b1, 80, 1'b1, 1'b0);
    cyc(1'b1, 80, 1'b1, 1'b0);
    cyc(1'b1, 80, 1'b1, 1'b1);
    clear_got();
    cyc(1'b1, 80, 1'b1, 1'b0);
    drain(3);
    chk("clr_cnt",  32'(got_y.size()), 32'd1);
    chk("clr_y",    32'(qy(0)), 32'd80);
    chk("clr_full", 32'(qf(0)), 32'd0);

    // Asynchronous reset mid-stream, then a fresh impulse.
    for (int i = 0; i < 5; i++) cyc(1'b1, int'($urandom_range(0, 255)), 1'b1, 1'b0);
    @(negedge CLK);
    bus.in_valid = 1'b0;
    #2 RST = 1'b0;
    #1;
    model_clear();
    check_reset_outputs("rst_mid");
    #2 RST = 1'b1;
    clear_got();
    cyc(1'b1, 128, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 0, 1'b1, 1'b0);
    drain(3);
    chk("rimp_y0", 32'(qy(0)), 32'd128);
    chk("rimp_y1", 32'(qy(1)), 32'd64);
    chk("rimp_y2", 32'(qy(2)), 32'd32);
    chk("rimp_y3", 32'(qy(3)), 32'd16);
    chk("rimp_f0", 32'(qf(0)), 32'd0);

    // Random traffic with stalls, bubbles and the odd clear.
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 4) != 0, int'($urandom_range(0, 255)),
          ($urandom % 4) != 0, ($urandom % 50) == 0);
    drain(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wma_filter_pipe.md
# wma_filter_pipe

Parametrised, pipelined successor to the team's 4-tap weighted moving average filter. Implements Yn = Σ (x[n-k] >> k) for k = 0..TAPS-1 over DATA_W-bit unsigned samples, with valid/ready flow control, a window-fill indicator, synchronous clear and an overflow flag. It sits in the DSP datapath between a sample source and any consumer that may apply backpressure.

## Interface
- DATA_W, 8: sample and output width, 4..16.
- TAPS, 4: window length; even, 2..16. Tap k weight is 2^-k.
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous active-low reset.
- CLR  in  1  synchronous clear: flushes taps, fill count and pipeline valids.
- Xn  in  DATA_W  input sample, unsigned.
- in_valid  in  1  Xn valid.
- in_ready  out  1  filter can accept a sample this cycle.
- Yn  out  DATA_W  filtered output.
- out_valid  out  1  Yn valid.
- out_ready  in  1  consumer accepts Yn.
- out_full  out  1  Yn computed from a full window (TAPS real samples).
- out_ovf  out  1  exact sum ≥ 2^DATA_W for this Yn.

## Operation
- adv = !out_valid || out_ready; in_ready = adv. A sample is accepted when in_valid && in_ready.
- Stage 0 (tap line): on accept, tap[0] <= Xn, tap[k] <= tap[k-1]; fill count increments, saturating at TAPS. No accept → taps hold.
- Term T_k = tap[k] >> k, truncated per term; T_k = 0 when k ≥ DATA_W.
- Stage 1: when adv, P_j <= T_2j + T_2j+1 (DATA_W+1 bits), v1 <= accept, f1 <= (fill count after accept == TAPS).
- Stage 2: when adv, S <= Σ P_j in DATA_W+1 bits (exact max < 2^(DATA_W+1)); out_valid <= v1; out_full <= f1; out_ovf <= S[DATA_W].
- Yn derived from S per Configuration.
- When !adv, every stage holds, including bubbles.
- CLR (when RST high): taps, fill count, v1, f1, out_valid, out_full, out_ovf, Yn cleared next edge; overrides simultaneous accept (that sample is dropped); in_ready in that cycle still follows adv.
- Reset values: Yn=0, out_valid=0, out_full=0, out_ovf=0, all taps and sums 0, fill count 0; in_ready=1 during and after reset.

## Timing
- Latency 2 cycles: sample accepted at edge E0 → Yn including it valid after E2, absent stalls.
- Throughput 1 sample/cycle when out_ready held high.
- Stall: out_valid && !out_ready freezes Yn and all flags until out_ready rises; in_ready low the same cycle (combinational from out_valid/out_ready).
- Reset asserted mid-stream: all state cleared asynchronously; first post-reset output treats prior samples as zero.

## Configuration
- WMA_SAT_EN defined: Yn = S[DATA_W] ? all ones : S[DATA_W-1:0] (saturating).
- Undefined: Yn = S[DATA_W-1:0] (wraps modulo 2^DATA_W, legacy behaviour). out_ovf reported identically in both modes.

## Structure
- Package wma_pkg: WMA_MAX_TAPS = 16, WMA_MAX_DATA_W = 16, clog2 function for fill-count width, term/sum width localparams.
- Sub-module wma_tap_line: tap shift register plus saturating fill counter and CLR handling; top holds the term/adder pipeline and handshake.

## Test plan
- DATA_W=8, TAPS=4, out_ready=1: impulse 128 then zeros → Yn = 128, 64, 32, 16, 0; out_full low for first 3 outputs, high from 4th.
- Constant 255 stream → steady Yn = 220, out_ovf=1 without WMA_SAT_EN; Yn = 255, out_ovf=1 with it.
- Constant 100 → steady 100+50+25+12 = 187, out_ovf=0.
- Backpressure: out_ready low 3 cycles with in_valid high → Yn/out_valid stable, in_ready low, no sample lost or duplicated after release.
- CLR asserted with in_valid after 2 samples of 80 → next outputs zero-based; following 80 gives Yn=80, out_full=0.
- RST pulsed mid-stream → all outputs 0 immediately; recovery sequence matches fresh-start impulse response.
